// File: rtl/qea.sv
// qea: quantum-state emulation accelerator. Applies 2x2 complex gates from a context RAM to a state RAM.
// Build option: define QEA_SAT_EN to saturate the final re/im adds instead of wrapping.
module qea #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
    parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
    parameter int GATE_ADDR_WIDTH         = 6,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 i_ctx_en,
    input  logic                                 i_ctx_wea,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic                                 i_state_ena,
    input  logic                                 i_state_wea,
    input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
    output logic                                 o_complete,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);

    localparam int RW        = PE_NUM*STATE_DATA_WIDTH;
    localparam int SDW       = STATE_DATA_WIDTH;
    localparam int ROWS      = 1 << STATE_ADDR_WIDTH;
    localparam int CTX_DEPTH = 1 << GATE_CONTEXT_ADDR_WIDTH;
    localparam int PW        = 2*ALU_DATA_WIDTH + 1;
    localparam int SW        = ALU_DATA_WIDTH + 3;
    localparam int CW        = STATE_ADDR_WIDTH + 1;

    localparam logic signed [SW:0] SAT_MAX = {{(SW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW:0] SAT_MIN = {{(SW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] ROW_ONE = CW'(1);
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] PC_ONE = GATE_CONTEXT_ADDR_WIDTH'(1);
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] PC_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOADU, S_RD0, S_RD1, S_CALC, S_WR0, S_WR1, S_NEXT, S_DONE
    } state_t;

    // (a*b +/- c*d) at full precision, then floor-shifted back to the fixed-point scale
    function automatic logic signed [SW-1:0] mac2(
        input logic signed [ALU_DATA_WIDTH-1:0] a, b, c, d,
        input logic                             neg
    );
        logic signed [PW-1:0] pa, pb, acc;
        pa  = PW'(a) * PW'(b);
        pb  = PW'(c) * PW'(d);
        acc = neg ? (pa - pb) : (pa + pb);
        acc = acc >>> NUM_FRAC_BIT;
        return acc[SW-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fin_add(input logic signed [SW-1:0] p, q);
        logic signed [SW:0]    s;
        logic [DATA_WIDTH-1:0] r;
        s = (SW+1)'(p) + (SW+1)'(q);
        r = s[DATA_WIDTH-1:0];
`ifdef QEA_SAT_EN
        if (s > SAT_MAX)
            r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (s < SAT_MIN)
            r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif
        return r;
    endfunction

    // ux*a0 + uy*a1 for one complex output amplitude
    function automatic logic [SDW-1:0] cgate(input logic [GATE_DATA_WIDTH-1:0] ux, uy,
                                             input logic [SDW-1:0] a0, a1);
        logic signed [ALU_DATA_WIDTH-1:0] uxr, uxi, uyr, uyi, a0r, a0i, a1r, a1i;
        logic [DATA_WIDTH-1:0] re, im;
        uxr = ux[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH];
        uxi = ux[ALU_DATA_WIDTH-1:0];
        uyr = uy[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH];
        uyi = uy[ALU_DATA_WIDTH-1:0];
        a0r = a0[SDW-1 -: ALU_DATA_WIDTH];
        a0i = a0[ALU_DATA_WIDTH-1:0];
        a1r = a1[SDW-1 -: ALU_DATA_WIDTH];
        a1i = a1[ALU_DATA_WIDTH-1:0];
        re = fin_add(mac2(uxr, a0r, uxi, a0i, 1'b1), mac2(uyr, a1r, uyi, a1i, 1'b1));
        im = fin_add(mac2(uxr, a0i, uxi, a0r, 1'b0), mac2(uyr, a1i, uyi, a1r, 1'b0));
        return {re, im};
    endfunction

    // lane of pair g when the target bit t lies inside the row: insert bit t (=hi) into g
    function automatic logic [PE_NUM_WIDTH-1:0] pair_lane(input logic [PE_NUM_WIDTH-1:0] g,
                                                          input logic [PE_NUM_WIDTH-1:0] t,
                                                          input logic hi);
        logic [PE_NUM_WIDTH:0] low_mask, v;
        low_mask = ((PE_NUM_WIDTH+1)'(1) << t) - (PE_NUM_WIDTH+1)'(1);
        v = (({1'b0, g} & ~low_mask) << 1) | ({1'b0, g} & low_mask);
        if (hi)
            v = v | ((PE_NUM_WIDTH+1)'(1) << t);
        return v[PE_NUM_WIDTH-1:0];
    endfunction

    function automatic logic [SDW-1:0] lane_of(input logic [RW-1:0] row,
                                               input logic [PE_NUM_WIDTH-1:0] idx);
        return row[(PE_NUM-1-int'(idx))*SDW +: SDW];
    endfunction

    logic [RW-1:0]                      r_state_mem [0:ROWS-1];
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_mem   [0:CTX_DEPTH-1];

    state_t                             r_state, w_state_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_dout;
    logic                               r_complete;
    logic [1:0]                         r_lcnt;
    logic [GATE_ADDR_WIDTH-1:0]         r_tgt;
    logic [MAX_QBIT_WIDTH-1:0]          r_nq;
    logic [CW-1:0]                      r_row, w_row_step, w_row1, w_sbit, w_rows_total;
    logic [GATE_DATA_WIDTH-1:0]         r_u [0:3];
    logic [RW-1:0]                      r_eng_dout, r_row0, r_res0, r_res1, r_state_dout;
    logic [RW-1:0]                      w_inter_r0, w_inter_r1, w_intra_row;
    logic [SDW-1:0]                     w_a0 [PE_NUM], w_a1 [PE_NUM], w_b0 [PE_NUM], w_b1 [PE_NUM];
    logic [PE_NUM_WIDTH-1:0]            w_lo_idx [PE_NUM], w_hi_idx [PE_NUM];
    logic                               w_busy, w_inter, w_skip, w_last;
    logic                               w_eng_re, w_eng_we;
    logic [STATE_ADDR_WIDTH-1:0]        w_eng_raddr, w_eng_waddr;
    logic [RW-1:0]                      w_eng_wdata;
    logic [GATE_ADDR_WIDTH-1:0]         w_s;
    logic [3:0]                         w_op;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_op    = r_ctx_dout[GATE_CONTEXT_DATA_WIDTH-1 -: 4];
    assign w_inter = r_tgt >= GATE_ADDR_WIDTH'(PE_NUM_WIDTH);
    assign w_skip  = r_tgt >= r_nq;
    assign w_s     = r_tgt - GATE_ADDR_WIDTH'(PE_NUM_WIDTH);
    assign w_sbit  = ROW_ONE << w_s;
    assign w_row1  = r_row | w_sbit;
    assign w_rows_total = ROW_ONE << (r_nq - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));

    // Next pair base row: skip rows that are the upper partner of an inter-row pair
    always_comb begin
        w_row_step = r_row + ROW_ONE;
        if (w_inter && ((w_row_step & w_sbit) != '0))
            w_row_step = w_row_step + w_sbit;
    end
    assign w_last = w_row_step >= w_rows_total;

    generate
        for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
            assign w_lo_idx[gi] = pair_lane(PE_NUM_WIDTH'(gi), r_tgt[PE_NUM_WIDTH-1:0], 1'b0);
            assign w_hi_idx[gi] = pair_lane(PE_NUM_WIDTH'(gi), r_tgt[PE_NUM_WIDTH-1:0], 1'b1);
            assign w_a0[gi] = w_inter ? lane_of(r_row0, PE_NUM_WIDTH'(gi))
                                      : lane_of(r_eng_dout, w_lo_idx[gi]);
            assign w_a1[gi] = w_inter ? lane_of(r_eng_dout, PE_NUM_WIDTH'(gi))
                                      : lane_of(r_eng_dout, w_hi_idx[gi]);
            assign w_b0[gi] = cgate(r_u[0], r_u[1], w_a0[gi], w_a1[gi]);
            assign w_b1[gi] = cgate(r_u[2], r_u[3], w_a0[gi], w_a1[gi]);
            assign w_inter_r0[(PE_NUM-1-gi)*SDW +: SDW] = w_b0[gi];
            assign w_inter_r1[(PE_NUM-1-gi)*SDW +: SDW] = w_b1[gi];
        end
    endgenerate

    always_comb begin
        w_intra_row = r_eng_dout;
        for (int g = 0; g < PE_NUM/2; g++) begin
            w_intra_row[(PE_NUM-1-int'(w_lo_idx[g]))*SDW +: SDW] = w_b0[g];
            w_intra_row[(PE_NUM-1-int'(w_hi_idx[g]))*SDW +: SDW] = w_b1[g];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_eng_re     = 1'b0;
        w_eng_we     = 1'b0;
        w_eng_raddr  = r_row[STATE_ADDR_WIDTH-1:0];
        w_eng_waddr  = r_row[STATE_ADDR_WIDTH-1:0];
        w_eng_wdata  = r_res0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = '0;
                end
            end
            S_FETCH: begin
                if (r_pc == PC_MAX || w_op == 4'h0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_pc_next = r_pc + PC_ONE;
                    if (w_op == 4'h1)
                        w_state_next = S_LOADU;
                end
            end
            S_LOADU: begin
                w_pc_next = r_pc + PC_ONE;
                if (r_lcnt == 2'd3)
                    w_state_next = w_skip ? S_NEXT : S_RD0;
            end
            S_RD0: begin
                w_eng_re     = 1'b1;
                w_state_next = w_inter ? S_RD1 : S_CALC;
            end
            S_RD1: begin
                w_eng_re     = 1'b1;
                w_eng_raddr  = w_row1[STATE_ADDR_WIDTH-1:0];
                w_state_next = S_CALC;
            end
            S_CALC: w_state_next = S_WR0;
            S_WR0: begin
                w_eng_we = 1'b1;
                if (w_inter)
                    w_state_next = S_WR1;
                else
                    w_state_next = w_last ? S_NEXT : S_RD0;
            end
            S_WR1: begin
                w_eng_we     = 1'b1;
                w_eng_waddr  = w_row1[STATE_ADDR_WIDTH-1:0];
                w_eng_wdata  = r_res1;
                w_state_next = w_last ? S_NEXT : S_RD0;
            end
            S_NEXT:  w_state_next = S_FETCH;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_complete <= 1'b0;
            r_lcnt     <= '0;
            r_tgt      <= '0;
            r_nq       <= '0;
            r_row      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_complete <= (w_state_next == S_DONE);
            r_lcnt     <= (r_state == S_LOADU) ? r_lcnt + 2'd1 : 2'd0;
            if ((r_state == S_IDLE || r_state == S_DONE) && i_start)
                r_nq <= i_qbit_num;
            if (r_state == S_FETCH && w_op == 4'h1)
                r_tgt <= r_ctx_dout[GATE_ADDR_WIDTH-1:0];
            if (r_state == S_LOADU && r_lcnt == 2'd3)
                r_row <= '0;
            else if ((r_state == S_WR0 && !w_inter) || r_state == S_WR1)
                r_row <= w_row_step;
        end
    end

    // Datapath registers carry no control meaning, so they are left out of reset
    always_ff @(posedge clk) begin
        if (r_state == S_LOADU)
            r_u[r_lcnt] <= r_ctx_dout;
        if (r_state == S_RD1)
            r_row0 <= r_eng_dout;
        if (r_state == S_CALC) begin
            r_res0 <= w_inter ? w_inter_r0 : w_intra_row;
            r_res1 <= w_inter_r1;
        end
    end

    // Context RAM read address follows the next PC so the fetched word lines up with r_pc
    always_ff @(posedge clk) begin
        if (i_ctx_en && i_ctx_wea && !w_busy)
            r_ctx_mem[i_ctx_addr] <= i_ctx_data;
        r_ctx_dout <= r_ctx_mem[w_pc_next];
    end

    always_ff @(posedge clk) begin
        if (i_state_ena && i_state_wea && !w_busy)
            r_state_mem[i_state_addra] <= i_state_dina;
        if (w_eng_we)
            r_state_mem[w_eng_waddr] <= w_eng_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_eng_re)
            r_eng_dout <= r_state_mem[w_eng_raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state_dout <= '0;
        else if (i_state_ena)
            r_state_dout <= r_state_mem[i_state_addra];
    end

    assign o_complete   = r_complete;
    assign o_state_dout = r_state_dout;

endmodule

// File: tb/tb_qea.sv
// Directed bench for qea: n=9 programs (HALT, H, X, skipped APPLY, saturation, mid-run reset).
// Expected rows are hand-computed; QEA_SAT_EN selects the saturation expectation.
module tb_qea;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [5:0]   i_qbit_num;
    logic         i_ctx_en, i_ctx_wea;
    logic [15:0]  i_ctx_addr;
    logic [63:0]  i_ctx_data;
    logic         i_state_ena, i_state_wea;
    logic [15:0]  i_state_addra;
    logic [255:0] i_state_dina;
    logic         o_complete;
    logic [255:0] o_state_dout;

    always #5 clk = ~clk;

    qea dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
        .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
        .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
        .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout)
    );

    localparam logic [63:0]  ONE   = 64'h40000000_00000000;
    localparam logic [63:0]  HP    = 64'h2D413CCC_00000000;
    localparam logic [63:0]  HN    = 64'hD2BEC334_00000000;
    localparam logic [63:0]  MAXP  = 64'h7FFFFFFF_00000000;
    localparam logic [63:0]  NOP   = 64'h30000000_00000000;
    localparam logic [63:0]  HALT  = 64'h0;
    localparam logic [255:0] L0ONE = {ONE, 192'd0};
`ifdef QEA_SAT_EN
    localparam logic [63:0]  SUMX  = 64'h7FFFFFFF_00000000;
`else
    localparam logic [63:0]  SUMX  = 64'hFFFFFFFE_00000000;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [255:0] rd;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s ok", tag);
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] apply(input int t);
        return {4'h1, 54'd0, 6'(t)};
    endfunction

    // All tasks start and end just after a falling edge
    task automatic ctx_wr(input int addr, input logic [63:0] data);
        i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = 16'(addr); i_ctx_data = data;
        @(negedge clk);
        i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
    endtask

    task automatic gate_wr(input int addr, input int t, input logic [63:0] u00, u01, u10, u11);
        ctx_wr(addr, apply(t));
        ctx_wr(addr + 1, u00);
        ctx_wr(addr + 2, u01);
        ctx_wr(addr + 3, u10);
        ctx_wr(addr + 4, u11);
    endtask

    task automatic row_wr(input int addr, input logic [255:0] data);
        i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'(addr); i_state_dina = data;
        @(negedge clk);
        i_state_ena = 1'b0; i_state_wea = 1'b0;
    endtask

    task automatic row_rd(input int addr, output logic [255:0] data);
        i_state_ena = 1'b1; i_state_wea = 1'b0; i_state_addra = 16'(addr);
        @(negedge clk);
        i_state_ena = 1'b0;
        data = o_state_dout;
    endtask

    task automatic init_state(input logic [255:0] row0);
        for (int r = 0; r < 128; r++)
            row_wr(r, (r == 0) ? row0 : 256'd0);
    endtask

    task automatic run(input string tag);
        int cyc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, "_clr"}, {255'd0, o_complete}, 256'd0);
        cyc = 0;
        while (!o_complete && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, {255'd0, o_complete}, 256'd1);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_qbit_num = 6'd9;
        i_ctx_en = 1'b0; i_ctx_wea = 1'b0; i_ctx_addr = '0; i_ctx_data = '0;
        i_state_ena = 1'b0; i_state_wea = 1'b0; i_state_addra = '0; i_state_dina = '0;
        repeat (3) @(negedge clk);
        check("rst_complete", {255'd0, o_complete}, 256'd0);
        check("rst_dout", o_state_dout, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // HALT only
        init_state(L0ONE);
        ctx_wr(0, HALT);
        run("halt");
        row_rd(0, rd);   check("halt_row0", rd, L0ONE);
        row_rd(1, rd);   check("halt_row1", rd, 256'd0);
        row_rd(127, rd); check("halt_row127", rd, 256'd0);
        check("halt_hold", {255'd0, o_complete}, 256'd1);

        // Hadamard on t=0
        init_state(L0ONE);
        gate_wr(0, 0, HP, HP, HP, HN);
        ctx_wr(5, HALT);
        run("h0");
        row_rd(0, rd); check("h0_row0", rd, {HP, HP, 128'd0});
        row_rd(1, rd); check("h0_row1", rd, 256'd0);

        // X on t=8: amplitude 0 moves to amplitude 256 (row 64)
        init_state(L0ONE);
        gate_wr(0, 8, 64'd0, ONE, ONE, 64'd0);
        ctx_wr(5, HALT);
        run("x8");
        row_rd(0, rd);  check("x8_row0", rd, 256'd0);
        row_rd(64, rd); check("x8_row64", rd, L0ONE);

        // t=9 on n=9 is skipped, NOP passes, X on t=8 swaps back
        gate_wr(0, 9, 64'd0, ONE, ONE, 64'd0);
        ctx_wr(5, NOP);
        gate_wr(6, 8, 64'd0, ONE, ONE, 64'd0);
        ctx_wr(11, HALT);
        run("skip");
        row_rd(0, rd);  check("skip_row0", rd, L0ONE);
        row_rd(64, rd); check("skip_row64", rd, 256'd0);

        // X on t=1 (lane 0 -> lane 2), then X on t=2 (row 0 -> row 1)
        init_state(L0ONE);
        gate_wr(0, 1, 64'd0, ONE, ONE, 64'd0);
        gate_wr(5, 2, 64'd0, ONE, ONE, 64'd0);
        ctx_wr(10, HALT);
        run("x12");
        row_rd(0, rd); check("x12_row0", rd, 256'd0);
        row_rd(1, rd); check("x12_row1", rd, {128'd0, ONE, 64'd0});

        // Overflowing sum: saturate or wrap depending on build
        init_state({MAXP, MAXP, 128'd0});
        gate_wr(0, 0, ONE, ONE, 64'd0, ONE);
        ctx_wr(5, HALT);
        run("sat");
        row_rd(0, rd); check("sat_row0", rd, {SUMX, MAXP, 128'd0});

        // Reset in the middle of a long inter-row gate
        init_state(L0ONE);
        gate_wr(0, 8, 64'd0, ONE, ONE, 64'd0);
        ctx_wr(5, HALT);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_busy", {255'd0, o_complete}, 256'd0);
        row_rd(0, rd);
        rst_n = 1'b0;
        #2;
        check("mid_rst_complete", {255'd0, o_complete}, 256'd0);
        check("mid_rst_dout", o_state_dout, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("abort_idle", {255'd0, o_complete}, 256'd0);
        run("rerun");
        row_rd(0, rd);  check("rerun_row0", rd, L0ONE);
        row_rd(64, rd); check("rerun_row64", rd, 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
